// File: rtl/gemm_pkg.sv
// gemm_pkg: shared FSM encoding, beat geometry and element/beat types for the GEMV sequencer.
package gemm_pkg;
  localparam int N_DEF = 8;
  localparam int WIDTH_DEF = 16;
  localparam int NUM_MACS_DEF = 2;
  localparam int E = N_DEF * NUM_MACS_DEF;
  localparam int TIMEOUT_CYCLES = 1024;
  typedef enum logic [2:0] {IDLE, PREFETCH, STREAM, WAIT_DONE, OUTPUT} state_t;
  typedef logic signed [WIDTH_DEF-1:0] elem_t;
  typedef elem_t [E-1:0] beat_t;
endpackage

// File: rtl/gemv_beat_mask.sv
// gemv_beat_mask: element enables for one beat; element e is live while e < remaining element count.
module gemv_beat_mask
  import gemm_pkg::*;
#(
  parameter int BE = E,
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] i_rem,
  output logic [BE-1:0]    o_mask
);
  for (genvar e = 0; e < BE; e++) begin : g_lane
    assign o_mask[e] = i_rem > CNT_W'(e);
  end
endmodule

// File: rtl/gemv_mac_sequencer.sv
// gemv_mac_sequencer: fetches GEMV operand beats and streams them into vec_mac, one start per dot.
// Optional MAC_TIMEOUT_EN: abort the job and set sticky err if vec_mac never signals done.
module gemv_mac_sequencer
  import gemm_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int NUM_MACS = NUM_MACS_DEF,
  parameter int ADDR_W = 10,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [CNT_W-1:0]           cmd_num_dots,
  input  logic [CNT_W-1:0]           cmd_row_size,
  input  logic [ADDR_W-1:0]          cmd_base_a,
  input  logic [ADDR_W-1:0]          cmd_base_b,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr_a,
  output logic [ADDR_W-1:0]          rd_addr_b,
  input  logic [NUM_MACS*N*WIDTH-1:0] rd_data_a,
  input  logic [NUM_MACS*N*WIDTH-1:0] rd_data_b,
  output logic                       mac_start,
  output logic [CNT_W-1:0]           mac_row_size,
  output logic [NUM_MACS*N*WIDTH-1:0] mac_vec_a,
  output logic [NUM_MACS*N*WIDTH-1:0] mac_vec_b,
  input  logic [2*WIDTH-1:0]         mac_result,
  input  logic                       mac_done,
  output logic                       res_valid,
  output logic [2*WIDTH-1:0]         res_data,
  input  logic                       res_ready,
  output logic                       busy,
  output logic                       err
);
  localparam int BE = N * NUM_MACS;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_dots, r_row, r_beats, r_j;
  logic [ADDR_W-1:0] r_row_a, r_base_b;
  logic [2*WIDTH-1:0] r_res;
  logic [CNT_W:0] w_sum;
  logic [CNT_W-1:0] w_beats, w_rd_j, w_rem;
  logic [BE-1:0] w_mask;
  logic w_timeout, w_last_beat;
  assign w_sum = {1'b0, cmd_row_size} + (CNT_W+1)'(BE - 1);
  assign w_beats = CNT_W'(w_sum / (CNT_W+1)'(BE));
  assign w_last_beat = r_j == r_beats - CNT_W'(1);
  assign w_rd_j = r_state == PREFETCH ? '0 : r_j + CNT_W'(1);
  assign w_rem = r_row - r_j * CNT_W'(BE);
  assign mac_row_size = r_row;
  assign res_data = r_res;
  gemv_beat_mask #(.BE(BE), .CNT_W(CNT_W)) u_mask (
    .i_rem (w_rem),
    .o_mask(w_mask)
  );
  // rd_data is the memory's registered output, so the beat read last cycle is presented now
  for (genvar e = 0; e < BE; e++) begin : g_vec
    assign mac_vec_a[e*WIDTH +: WIDTH] = (r_state == STREAM && w_mask[e]) ? rd_data_a[e*WIDTH +: WIDTH] : '0;
    assign mac_vec_b[e*WIDTH +: WIDTH] = (r_state == STREAM && w_mask[e]) ? rd_data_b[e*WIDTH +: WIDTH] : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (cmd_valid && cmd_num_dots != '0) w_next = cmd_row_size == '0 ? OUTPUT : PREFETCH;
      PREFETCH:  w_next = STREAM;
      STREAM:    if (w_last_beat) w_next = WAIT_DONE;
      WAIT_DONE: w_next = mac_done ? OUTPUT : w_timeout ? IDLE : WAIT_DONE;
      OUTPUT:    if (res_ready) w_next = r_dots == CNT_W'(1) ? IDLE : r_row == '0 ? OUTPUT : PREFETCH;
      default:   w_next = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = r_state == IDLE;
    busy = r_state != IDLE;
    res_valid = r_state == OUTPUT;
    mac_start = r_state == STREAM && r_j == '0;
    rd_en = r_state == PREFETCH || (r_state == STREAM && r_j + CNT_W'(1) < r_beats);
    rd_addr_a = rd_en ? r_row_a + ADDR_W'(w_rd_j) : '0;
    rd_addr_b = rd_en ? r_base_b + ADDR_W'(w_rd_j) : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dots <= '0;
      r_row <= '0;
      r_beats <= '0;
      r_j <= '0;
      r_row_a <= '0;
      r_base_b <= '0;
      r_res <= '0;
    end else begin
      if (r_state == IDLE && cmd_valid) begin
        r_dots <= cmd_num_dots;
        r_row <= cmd_row_size;
        r_beats <= w_beats;
        r_row_a <= cmd_base_a;
        r_base_b <= cmd_base_b;
      end
      if (r_state == PREFETCH) r_j <= '0;
      if (r_state == STREAM) r_j <= r_j + CNT_W'(1);
      if (r_state == WAIT_DONE && mac_done) r_res <= mac_result;
      else if (r_state == IDLE && w_next == OUTPUT) r_res <= '0;
      if (r_state == OUTPUT && res_ready) begin
        r_dots <= r_dots - CNT_W'(1);
        r_row_a <= r_row_a + ADDR_W'(r_beats);
      end
    end
  end
`ifdef MAC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] r_to_cnt;
  logic r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_to_cnt <= r_state == WAIT_DONE ? r_to_cnt + TW'(1) : '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end
  assign w_timeout = r_state == WAIT_DONE && !mac_done && r_to_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: doc/gemv_mac_sequencer.md
Name: gemv_mac_sequencer

Overview:
Command-driven sequencer that drives the start/done side of the vec_mac dot-product engine. It accepts a matrix-vector job, fetches operand beats from a synchronous operand memory, and streams them into vec_mac with a single start pulse per dot product. It captures each result on done and emits it on a valid/ready result port. It sits between the GEMM control path and vec_mac, as the initiator for vec_mac's responder.

Parameters:
N, 8, elements per MAC lane vector
WIDTH, 16, signed element width
NUM_MACS, 2, MAC units; beat = NUM_MACS*N elements (E)
ADDR_W, 10, operand memory address width
CNT_W, 16, width of row_size / num_dots fields

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  job request
cmd_ready  out  1  high only in IDLE
cmd_num_dots  in  CNT_W  dot products (rows of A)
cmd_row_size  in  CNT_W  elements per dot product
cmd_base_a  in  ADDR_W  beat address of A row 0
cmd_base_b  in  ADDR_W  beat address of vector B
rd_en  out  1  operand read strobe
rd_addr_a  out  ADDR_W  A beat address
rd_addr_b  out  ADDR_W  B beat address
rd_data_a  in  NUM_MACS*N*WIDTH  A beat, valid 1 cycle after rd_en
rd_data_b  in  NUM_MACS*N*WIDTH  B beat, valid 1 cycle after rd_en
mac_start  out  1  one-cycle start to vec_mac
mac_row_size  out  CNT_W  row_size to vec_mac, held for the job
mac_vec_a  out  NUM_MACS*N*WIDTH  masked A beat
mac_vec_b  out  NUM_MACS*N*WIDTH  masked B beat
mac_result  in  2*WIDTH  vec_mac result
mac_done  in  1  vec_mac completion
res_valid  out  1  result available
res_data  out  2*WIDTH  signed dot-product result
res_ready  in  1  result accepted
busy  out  1  state != IDLE
err  out  1  sticky timeout flag (see Optional Feature)

Behaviour:
- Reset: all outputs 0 except cmd_ready=1; FSM to IDLE; counters cleared.
- BEATS = ceil(row_size/E). Element e of a beat maps to mac e/N, lane e%N.
- Dot k reads A at base_a + k*BEATS + j and B at base_b + j, for j = 0..BEATS-1.
- FSM states:
  - IDLE: on cmd_valid & cmd_ready, latch the command.
    - num_dots == 0: stay IDLE; no result is produced.
    - Otherwise go to PREFETCH.
  - PREFETCH: rd_en=1 for beat 0, go to STREAM.
  - STREAM: beat j is presented on mac_vec_a/b, registered from rd_data.
    - mac_start=1 only with beat 0.
    - rd_en issues beat j+1 in the same cycle, so one beat is delivered per cycle with no bubbles.
    - After beat BEATS-1, go to WAIT_DONE.
  - WAIT_DONE: mac_vec_a/b driven 0. On mac_done, register mac_result into res_data and go to OUTPUT.
  - OUTPUT: res_valid=1 and stable until res_ready.
    - On handshake, if more dots remain, go to PREFETCH; otherwise go to IDLE.
- Masking: in the last beat, elements at index >= row_size - (BEATS-1)*E are forced to 0 on both operands.
- row_size == 0: MAC is never started; each dot goes directly to OUTPUT with res_data=0.
- mac_done outside WAIT_DONE is ignored.
- mac_row_size and res_data hold their last values until overwritten.
- Address arithmetic wraps modulo 2^ADDR_W.
- Reset mid-job aborts immediately. No result is emitted for the aborted job, and err is cleared.
- Latency per dot: 1 (PREFETCH) + BEATS + vec_mac latency + 1 cycle to res_valid.

Optional Feature:
- Macro: MAC_TIMEOUT_EN.
- When defined: a counter runs in WAIT_DONE. If 1024 cycles pass without mac_done:
  - set err (sticky until reset);
  - drop remaining dots;
  - return to IDLE with no res_valid.
- When undefined: WAIT_DONE waits indefinitely; err is tied to 0.

Decomposition:
- Shared package gemm_pkg holds: FSM state enum (IDLE, PREFETCH, STREAM, WAIT_DONE, OUTPUT), E localparam, TIMEOUT_CYCLES=1024, and the element/beat packed typedefs.
- One sub-module: gemv_beat_mask, a lane mask generator from the remaining-element count, instantiated once and applied to both operands.

Test Plan:
All scenarios use a behavioural vec_mac model. Default configuration (N=8, NUM_MACS=2, E=16). Every lane holds the pattern A=5,7,4,1,9,2,3,6 and B=3,2,6,8,0,5,7,4, which gives 116 per lane-vector.
1. num_dots=1, row_size=32 -> exactly one mac_start, 2 consecutive beats, res_data=464.
2. num_dots=1, row_size=20, nonzero garbage beyond element 20 -> last beat masked, res_data=232+61=293.
3. num_dots=3, row_size=16, res_ready held low 5 cycles per result -> res_data stable while stalled; 3 results of 232; A addresses base_a+0, +1, +2.
4. num_dots=0 -> returns to IDLE, no res_valid. num_dots=2, row_size=0 -> two results of 0, mac_start never asserted.
5. rst asserted mid-STREAM -> outputs at reset values next edge; a new job afterwards completes correctly.
6. MAC_TIMEOUT_EN defined, model never asserts done -> err=1 after 1024 WAIT_DONE cycles, busy=0, no res_valid.
